// File: rtl/dma_read_requester.sv
`default_nettype none
// ============================================================================
// Module  : dma_read_requester
// Purpose : Splits a DMA read command into boundary-safe bursts and issues each
//           one only when fifo free space covers every outstanding word.
//           Optional response watchdog: define DMA_REQ_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
module dma_read_requester #(
    parameter int BITS_DEPTH = 8,
    parameter int BITS_WIDTH = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 16,
    parameter int BOUND_BITS = 12
`ifdef DMA_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [LEN_W-1:0]      req_len,
    input  logic                  rsp_valid,
    input  logic [BITS_WIDTH-1:0] rsp_data,
    input  logic [BITS_WIDTH-1:0] fifo_elements,
    input  logic                  fifo_full,
    output logic [BITS_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    output logic                  busy,
    output logic                  done
`ifdef DMA_REQ_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    localparam int BYTES = BITS_WIDTH / 8;
    localparam int OUTW  = BITS_DEPTH + 1;
    localparam int BNDW  = BOUND_BITS + 1;
    localparam int CW    = ((LEN_W > BNDW) ? LEN_W : BNDW) + 1;

    localparam logic [OUTW-1:0]   C_DEPTH   = OUTW'(1) << BITS_DEPTH;
    localparam logic [BNDW-1:0]   C_BOUND   = BNDW'(1) << BOUND_BITS;
    localparam logic [BNDW-1:0]   C_BYTES_B = BNDW'(BYTES);
    localparam logic [ADDR_W-1:0] C_BYTES_A = ADDR_W'(BYTES);
    localparam logic [CW-1:0]     C_MAX     = CW'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_WAIT  = 3'd2,
        S_REQ   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W-1:0]     req_addr_q;
    logic [LEN_W-1:0]      remaining_q;
    logic [LEN_W-1:0]      blen_q;
    logic [LEN_W-1:0]      req_len_q;
    logic [OUTW-1:0]       outstanding_q;
    logic [OUTW-1:0]       outstanding_d;
    logic                  cmd_ready_q;
    logic                  req_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  fifo_wr_en_q;
    logic [BITS_WIDTH-1:0] fifo_din_q;

    logic                  hs;
    logic                  rsp_ok;
    logic [OUTW-1:0]       free;
    logic [OUTW:0]         need;
    logic [BNDW-1:0]       bound_words;
    logic [CW-1:0]         blen_c;
    logic                  unused_elements_hi;

`ifdef DMA_REQ_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0] tmo_cnt_q;
    logic           timeout_q;
`endif

    assign hs     = req_valid_q && req_ready;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign rsp_ok = rsp_valid && (outstanding_q != '0);

    assign free        = fifo_full ? '0 : C_DEPTH - {1'b0, fifo_elements[BITS_DEPTH-1:0]};
    assign need        = {1'b0, outstanding_q} + {1'b0, OUTW'(blen_q)};
    assign bound_words = (C_BOUND - {1'b0, addr_q[BOUND_BITS-1:0]}) / C_BYTES_B;

    assign unused_elements_hi = ^fifo_elements[BITS_WIDTH-1:BITS_DEPTH];

    always_comb begin
        blen_c = CW'(remaining_q);
        if (C_MAX < blen_c) begin
            blen_c = C_MAX;
        end
        if (CW'(bound_words) < blen_c) begin
            blen_c = CW'(bound_words);
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (hs) begin
            outstanding_d = outstanding_d + OUTW'(blen_q);
        end
        if (rsp_ok) begin
            outstanding_d = outstanding_d - OUTW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            req_addr_q    <= '0;
            remaining_q   <= '0;
            blen_q        <= '0;
            req_len_q     <= '0;
            outstanding_q <= '0;
            cmd_ready_q   <= 1'b1;
            req_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fifo_wr_en_q  <= 1'b0;
            fifo_din_q    <= '0;
`ifdef DMA_REQ_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            done_q        <= 1'b0;
            fifo_wr_en_q  <= rsp_ok;
            fifo_din_q    <= rsp_data;
            outstanding_q <= outstanding_d;

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len != '0) begin
                            addr_q      <= cmd_addr;
                            remaining_q <= cmd_len;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= S_CALC;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    blen_q  <= LEN_W'(blen_c);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if ({1'b0, free} >= need) begin
                        req_valid_q <= 1'b1;
                        req_addr_q  <= addr_q;
                        req_len_q   <= blen_q;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        remaining_q <= remaining_q - blen_q;
                        addr_q      <= addr_q + ADDR_W'(blen_q) * C_BYTES_A;
                        state_q     <= (remaining_q != blen_q) ? S_CALC : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outstanding_q == '0) begin
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

`ifdef DMA_REQ_TIMEOUT_EN
            // Watchdog overrides the FSM: abandon the command without a done pulse.
            timeout_q <= 1'b0;
            if (hs || rsp_valid) begin
                tmo_cnt_q <= '0;
            end else if (outstanding_q != '0) begin
                if (tmo_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                    tmo_cnt_q     <= '0;
                    timeout_q     <= 1'b1;
                    outstanding_q <= '0;
                    remaining_q   <= '0;
                    req_valid_q   <= 1'b0;
                    cmd_ready_q   <= 1'b1;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TCW'(1);
                end
            end
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign req_valid  = req_valid_q;
    assign req_addr   = req_addr_q;
    assign req_len    = req_len_q;
    assign fifo_din   = fifo_din_q;
    assign fifo_wr_en = fifo_wr_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef DMA_REQ_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif

endmodule
`default_nettype wire
